// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC register, IF/ID pipeline register,
// branch/jump redirect, load-use stall, and a RUN/HALT state machine.
// Ports: clk/CLR (async active-high reset); Stall, Branch_taken/BranchTarget,
//   JMP/JR/jaddr, Halt are control inputs from ID/EX; IM_addr/IM_data are the
//   combinational instruction-memory interface; IR/PC4_ID/Valid_ID form the
//   IF/ID register; Flush flags a bubble this cycle; Halted and InstrCount
//   report status.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        Stall,
  input  logic        Branch_taken,
  input  logic [31:0] BranchTarget,
  input  logic        JMP,
  input  logic        JR,
  input  logic [31:0] jaddr,
  input  logic        Halt,
  output logic [31:0] IM_addr,
  input  logic [31:0] IM_data,
  output logic [31:0] IR,
  output logic [31:0] PC4_ID,
  output logic        Valid_ID,
  output logic        Flush,
  output logic        Halted,
  output logic [31:0] InstrCount
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] jump_tgt;
  logic        jump_take;
  logic        halt_take;
  logic        bubble;
  logic        load_fetch;

  assign IM_addr  = pc;
  assign pc_plus4 = pc + 32'd4;

  // J/JAL keep the region bits of the jump instruction's own PC+4.
  assign jump_tgt = JR ? jaddr : {PC4_ID[31:28], jaddr[25:0], 2'b00};

  // Jumps and halts act only on a real instruction that is not stalled in ID.
  assign jump_take = (JMP | JR) & Valid_ID & ~Stall;
  assign halt_take = Halt & Valid_ID & ~Stall & ~Branch_taken;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    bubble     = 1'b0;
    load_fetch = 1'b0;
    case (state)
      RUN: begin
        if (Branch_taken) begin
          // A resolved branch wins over a stall: the stalled ID instruction
          // is on the wrong path anyway.
          pc_nxt = BranchTarget;
          bubble = 1'b1;
        end else if (halt_take) begin
          state_nxt = HALT;
          bubble    = 1'b1;
        end else if (jump_take) begin
          pc_nxt = jump_tgt;
          bubble = 1'b1;
        end else if (!Stall) begin
          pc_nxt     = pc_plus4;
          load_fetch = 1'b1;
        end
      end
      HALT: begin
        bubble = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign Flush  = bubble & ~CLR;
  assign Halted = (state == HALT);

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state      <= RUN;
      pc         <= RESET_PC;
      IR         <= 32'h0;
      PC4_ID     <= 32'h0;
      Valid_ID   <= 1'b0;
      InstrCount <= 32'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (bubble) begin
        IR       <= 32'h0;
        PC4_ID   <= 32'h0;
        Valid_ID <= 1'b0;
      end else if (load_fetch) begin
        IR         <= IM_data;
        PC4_ID     <= pc_plus4;
        Valid_ID   <= 1'b1;
        InstrCount <= InstrCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scoreboard bench for if_stage.
// Expected IF/ID contents, PC and counters are queued as each step's stimulus
// is applied and compared one cycle later after the clock edge.
module tb_if_stage;

  logic        clk;
  logic        CLR;
  logic        Stall;
  logic        Branch_taken;
  logic [31:0] BranchTarget;
  logic        JMP;
  logic        JR;
  logic [31:0] jaddr;
  logic        Halt;
  logic [31:0] IM_addr;
  logic [31:0] IM_data;
  logic [31:0] IR;
  logic [31:0] PC4_ID;
  logic        Valid_ID;
  logic        Flush;
  logic        Halted;
  logic [31:0] InstrCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc4;
    logic        vld;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        hlt;
  } exp_t;

  exp_t sb[$];

  if_stage dut (
    .clk(clk), .CLR(CLR), .Stall(Stall), .Branch_taken(Branch_taken),
    .BranchTarget(BranchTarget), .JMP(JMP), .JR(JR), .jaddr(jaddr),
    .Halt(Halt), .IM_addr(IM_addr), .IM_data(IM_data), .IR(IR),
    .PC4_ID(PC4_ID), .Valid_ID(Valid_ID), .Flush(Flush), .Halted(Halted),
    .InstrCount(InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-indexed instruction memory contents.
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hE700_0000 ^ a;
  endfunction

  assign IM_data = word(IM_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected post-edge state, clock once, then pop and compare.
  task automatic step(input string tag, input logic [31:0] ir, input logic [31:0] pc4,
                      input logic vld, input logic [31:0] addr, input logic [31:0] cnt,
                      input logic hlt);
    exp_t e;
    e.ir = ir; e.pc4 = pc4; e.vld = vld; e.addr = addr; e.cnt = cnt; e.hlt = hlt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".IR"},         IR,                 e.ir);
    chk({tag, ".PC4_ID"},     PC4_ID,             e.pc4);
    chk({tag, ".Valid_ID"},   {31'h0, Valid_ID},  {31'h0, e.vld});
    chk({tag, ".IM_addr"},    IM_addr,            e.addr);
    chk({tag, ".InstrCount"}, InstrCount,         e.cnt);
    chk({tag, ".Halted"},     {31'h0, Halted},    {31'h0, e.hlt});
  endtask

  task automatic chk_flush(input string tag, input logic exp);
    #1;
    chk({tag, ".Flush"}, {31'h0, Flush}, {31'h0, exp});
  endtask

  task automatic idle();
    Stall = 1'b0; Branch_taken = 1'b0; BranchTarget = 32'h0;
    JMP = 1'b0; JR = 1'b0; jaddr = 32'h0; Halt = 1'b0;
  endtask

  initial begin
    idle();
    CLR = 1'b1;
    // Flush must stay low under reset even with a redirect request present.
    Branch_taken = 1'b1;
    BranchTarget = 32'h0000_0400;
    #2;
    chk("rst.Flush", {31'h0, Flush}, 32'h0);
    chk("rst.IM_addr", IM_addr, 32'h0);
    chk("rst.IR", IR, 32'h0);
    chk("rst.Valid_ID", {31'h0, Valid_ID}, 32'h0);
    chk("rst.InstrCount", InstrCount, 32'h0);
    #5; // past the t=5 edge, still in reset
    chk("rst_edge.IM_addr", IM_addr, 32'h0);
    idle();
    #1 CLR = 1'b0;

    // Sequential fetch from reset.
    step("seq0", word(32'h0), 32'h4, 1'b1, 32'h4, 32'd1, 1'b0);
    step("seq1", word(32'h4), 32'h8, 1'b1, 32'h8, 32'd2, 1'b0);
    step("seq2", word(32'h8), 32'hC, 1'b1, 32'hC, 32'd3, 1'b0);

    // Two-cycle load-use stall holds everything.
    Stall = 1'b1;
    chk_flush("stall", 1'b0);
    step("stall0", word(32'h8), 32'hC, 1'b1, 32'hC, 32'd3, 1'b0);
    step("stall1", word(32'h8), 32'hC, 1'b1, 32'hC, 32'd3, 1'b0);
    Stall = 1'b0;
    step("resume", word(32'hC), 32'h10, 1'b1, 32'h10, 32'd4, 1'b0);

    // Branch into the 0x0040_000C region so the jump sees PC4_ID=0x0040_0010.
    Branch_taken = 1'b1;
    BranchTarget = 32'h0040_000C;
    chk_flush("br1", 1'b1);
    step("br1", 32'h0, 32'h0, 1'b0, 32'h0040_000C, 32'd4, 1'b0);
    idle();
    step("br1_fetch", word(32'h0040_000C), 32'h0040_0010, 1'b1, 32'h0040_0010, 32'd5, 1'b0);

    // J: target keeps PC4_ID[31:28]=0 -> 0x100, one-cycle bubble.
    JMP = 1'b1;
    jaddr = 32'h0000_0040;
    chk_flush("jmp", 1'b1);
    step("jmp", 32'h0, 32'h0, 1'b0, 32'h0000_0100, 32'd5, 1'b0);
    // JMP still high but IR is a bubble: it must be ignored.
    chk_flush("jmp_novld", 1'b0);
    step("jmp_novld", word(32'h100), 32'h104, 1'b1, 32'h104, 32'd6, 1'b0);
    // JMP under stall is ignored as well.
    Stall = 1'b1;
    chk_flush("jmp_stall", 1'b0);
    step("jmp_stall", word(32'h100), 32'h104, 1'b1, 32'h104, 32'd6, 1'b0);

    // JR uses the full register value.
    idle();
    JR = 1'b1;
    jaddr = 32'hF000_3000;
    chk_flush("jr", 1'b1);
    step("jr", 32'h0, 32'h0, 1'b0, 32'hF000_3000, 32'd6, 1'b0);
    idle();
    step("jr_fetch", word(32'hF000_3000), 32'hF000_3004, 1'b1, 32'hF000_3004, 32'd7, 1'b0);

    // Branch overrides a simultaneous stall and JR.
    Branch_taken = 1'b1;
    BranchTarget = 32'h0000_0200;
    Stall = 1'b1;
    JR = 1'b1;
    jaddr = 32'h0000_5000;
    chk_flush("br2", 1'b1);
    step("br2", 32'h0, 32'h0, 1'b0, 32'h200, 32'd7, 1'b0);
    idle();
    step("br2_f0", word(32'h200), 32'h204, 1'b1, 32'h204, 32'd8, 1'b0);
    step("br2_f1", word(32'h204), 32'h208, 1'b1, 32'h208, 32'd9, 1'b0);

    // Halt: PC frozen, bubbles, ignores later redirects.
    Halt = 1'b1;
    chk_flush("halt", 1'b1);
    step("halt", 32'h0, 32'h0, 1'b0, 32'h208, 32'd9, 1'b1);
    idle();
    Branch_taken = 1'b1;
    BranchTarget = 32'h0000_0800;
    chk_flush("halted", 1'b1);
    step("halted0", 32'h0, 32'h0, 1'b0, 32'h208, 32'd9, 1'b1);
    idle();
    step("halted1", 32'h0, 32'h0, 1'b0, 32'h208, 32'd9, 1'b1);

    // Mid-cycle CLR pulse in HALT resets immediately, without a clock edge.
    #2 CLR = 1'b1;
    #1;
    chk("clr.IM_addr", IM_addr, 32'h0);
    chk("clr.Halted", {31'h0, Halted}, 32'h0);
    chk("clr.InstrCount", InstrCount, 32'h0);
    chk("clr.Flush", {31'h0, Flush}, 32'h0);
    #2 CLR = 1'b0;
    step("clr_fetch", word(32'h0), 32'h4, 1'b1, 32'h4, 32'd1, 1'b0);

    // CLR mid-stall with a pending branch discards the redirect.
    Stall = 1'b1;
    Branch_taken = 1'b1;
    BranchTarget = 32'h0000_0900;
    #2 CLR = 1'b1;
    #1;
    chk("clr2.IM_addr", IM_addr, 32'h0);
    chk("clr2.IR", IR, 32'h0);
    idle();
    #2 CLR = 1'b0;
    step("clr2_fetch", word(32'h0), 32'h4, 1'b1, 32'h4, 32'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Ports: clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 Ports: CLR  input  1  asynchronous, active-high reset.
REQ-004 Ports: Stall  input  1  load-use hazard from ID, holds PC and IF/ID register.
REQ-005 Ports: Branch_taken  input  1  branch resolved taken in EX.
REQ-006 Ports: BranchTarget  input  32  branch target byte address from EX.
REQ-007 Ports: JMP  input  1  ID-stage instruction is J or JAL.
REQ-008 Ports: JR  input  1  ID-stage instruction is JR.
REQ-009 Ports: jaddr  input  32  from ID, register value when JR, else zero-extended IR[25:0].
REQ-010 Ports: Halt  input  1  ID-stage SYSCALL exit request.
REQ-011 Ports: IM_addr  output  32  instruction memory byte address.
REQ-012 Ports: IM_data  input  32  instruction word, combinational read of IM_addr.
REQ-013 Ports: IR  output  32  IF/ID instruction register, drives ID.
REQ-014 Ports: PC4_ID  output  32  PC+4 of the instruction in IR.
REQ-015 Ports: Valid_ID  output  1  IR holds a real, non-bubble instruction.
REQ-016 Ports: Flush  output  1  combinational, high when IF/ID is being bubbled this cycle.
REQ-017 Ports: Halted  output  1  halt state indicator.
REQ-018 Ports: InstrCount  output  32  count of instructions delivered into IR.

Function
REQ-019 IM_addr SHALL equal the PC register combinationally; PC increments by 4, wraps modulo 2^32.
REQ-020 Jump target SHALL be jaddr when JR, else {PC4_ID[31:28], jaddr[25:0], 2'b00}.
REQ-021 Next-PC priority SHALL be: HALT state hold > Branch_taken > (JMP|JR) with Valid_ID and not Stall > Stall hold > PC+4.
REQ-022 Branch_taken SHALL override Stall: PC <= BranchTarget and IF/ID <= bubble in the same edge.
REQ-023 JMP/JR SHALL be ignored while Stall=1 or Valid_ID=0; when taken, PC <= jump target and IF/ID <= bubble (no delay slot).
REQ-024 Bubble SHALL mean IR=32'h0, PC4_ID=0, Valid_ID=0; Flush SHALL be high exactly on cycles producing a bubble.
REQ-025 With no redirect and Stall=0 in RUN, IF/ID SHALL load IR<=IM_data, PC4_ID<=PC+4, Valid_ID<=1, and PC<=PC+4.
REQ-026 With Stall=1 and no Branch_taken, PC, IR, PC4_ID, Valid_ID SHALL hold; fetch latency IM to IR is one cycle.
REQ-027 FSM states SHALL be RUN and HALT; RUN->HALT when Halt=1, Valid_ID=1, Stall=0, Branch_taken=0.
REQ-028 On RUN->HALT edge and throughout HALT, PC SHALL hold, IF/ID SHALL be bubble, Halted=1; HALT exits only via CLR.
REQ-029 InstrCount SHALL increment by 1 on every edge loading Valid_ID<=1, wrapping 32'hFFFF_FFFF->0.

Reset
REQ-030 CLR=1 SHALL immediately, independent of clk, set PC=RESET_PC, IR=0, PC4_ID=0, Valid_ID=0, Halted=0, InstrCount=0, state RUN.
REQ-031 CLR asserted mid-stall, mid-redirect or in HALT SHALL discard all pending redirects; first fetch after release at RESET_PC.
REQ-032 Flush SHALL be 0 while CLR=1.

Verification
REQ-033 Reset release, IM returns addr-indexed words, no controls -> IM_addr 0,4,8; IR sequence word(0),word(4); PC4_ID 4,8; InstrCount 1,2.
REQ-034 Stall=1 for 2 cycles with IR=word(8) -> IR, PC4_ID=12, PC=12 held; InstrCount unchanged; resumes with word(12).
REQ-035 JMP=1, jaddr=26'h0000040, PC4_ID=32'h0040_0010 -> next IM_addr 32'h0000_0100, Flush=1, IR=0, Valid_ID=0 for one cycle.
REQ-036 Branch_taken=1, BranchTarget=32'h200 with simultaneous Stall=1 and JR=1 -> PC=32'h200, IR bubbled, JR ignored.
REQ-037 Halt=1 with Valid_ID=1, Stall=0 -> Halted=1 next edge, PC frozen, IR=0 indefinitely; CLR pulse mid-cycle -> PC=RESET_PC asynchronously, Halted=0.
